// File: rtl/sseg_scan_scheduler_if.sv
// Update handshake bundle between the BCD result logic and the scan scheduler.
// The producer drives the digit set; the scheduler answers with upd_ready.
interface sseg_scan_scheduler_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [3:0] one;
  logic [3:0] ten;
  logic [3:0] hunnid;
  logic [3:0] thousand;

  modport master (
    output upd_valid,
    output one,
    output ten,
    output hunnid,
    output thousand,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  one,
    input  ten,
    input  hunnid,
    input  thousand,
    output upd_ready
  );
endinterface

// File: rtl/sseg_scan_scheduler.sv
// 4-digit seven-segment scan scheduler: slot timing, anode guard, LZ blanking
// and frame-synchronous commit of new digit sets.
module sseg_scan_scheduler #(
  parameter int TICK_DIV     = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  sseg_scan_scheduler_if.slave  upd,
  input  logic                  lz_en,
  output logic [1:0]            select,
  output logic [3:0]            digit,
  output logic                  blank,
  output logic                  frame_tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    sel_n;
  logic          wrap;
  logic          boundary;
  logic          commit;
  logic          accept;
  logic [15:0]   disp;
  logic [15:0]   disp_n;
  logic [15:0]   pend;
  logic          lz_q;
  logic          lz_now;
  logic          blank_n;
  logic          tick_n;
  logic [3:0]    digit_n;

  assign wrap     = (cnt == LAST);
  assign boundary = wrap && (select == 2'd3);
  // upd_ready low means an accepted set is waiting for the boundary
  assign commit   = boundary && !upd.upd_ready;
  assign accept   = upd.upd_valid && upd.upd_ready;

  assign cnt_n  = wrap ? '0 : cnt + CW'(1);
  assign sel_n  = wrap ? select + 2'd1 : select;
  assign disp_n = commit ? pend : disp;
  assign tick_n = (cnt_n == LAST) && (sel_n == 2'd3);

  always_comb begin
    lz_now = 1'b0;
    unique case (select)
      2'd3: lz_now = (disp[15:12] == 4'd0);
      2'd2: lz_now = (disp[15:8] == 8'd0);
      2'd1: lz_now = (disp[15:4] == 12'd0);
      2'd0: lz_now = 1'b0;
    endcase
    lz_now = lz_now && lz_en;
  end

  always_comb begin
    digit_n = disp_n[3:0];
    unique case (sel_n)
      2'd0: digit_n = disp_n[3:0];
      2'd1: digit_n = disp_n[7:4];
      2'd2: digit_n = disp_n[11:8];
      2'd3: digit_n = disp_n[15:12];
    endcase
  end

  // LZ decision is frozen during the slot-start cycle, used from cnt=1 on
  always_comb begin
    blank_n = (cnt_n < GUARD);
    if (cnt == '0)
      blank_n = blank_n || lz_now;
    else
      blank_n = blank_n || lz_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      select        <= 2'd0;
      digit         <= 4'd0;
      blank         <= 1'b1;
      frame_tick    <= 1'b0;
      upd.upd_ready <= 1'b1;
      disp          <= 16'd0;
      pend          <= 16'd0;
      lz_q          <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      select     <= sel_n;
      digit      <= digit_n;
      blank      <= blank_n;
      frame_tick <= tick_n;
      if (cnt == '0)
        lz_q <= lz_now;
      if (commit) begin
        disp          <= pend;
        upd.upd_ready <= 1'b1;
      end else if (accept) begin
        pend          <= {upd.thousand, upd.hunnid,
                          upd.ten, upd.one};
        upd.upd_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_scheduler.sv
// Randomized bench for sseg_scan_scheduler against a cycle-count based
// reference model (slot/frame derived from elapsed cycles since reset).
module tb_sseg_scan_scheduler;

  localparam int TD = 8;
  localparam int G  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lz_en = 1'b0;
  logic [1:0] select;
  logic [3:0] digit;
  logic       blank;
  logic       frame_tick;

  sseg_scan_scheduler_if u_if ();

  sseg_scan_scheduler #(
    .TICK_DIV     (TD),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .upd        (u_if),
    .lz_en      (lz_en),
    .select     (select),
    .digit      (digit),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          k;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          m_lz;
  bit          lz_g;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h k=%0d", tag, got, exp, k);
    end
  endtask

  function automatic logic [15:0] rval();
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
    return r;
  endfunction

  task automatic check_now();
    int   cnt;
    int   slot;
    bit   lzb;
    logic [15:0] above;
    cnt   = k % TD;
    slot  = (k / TD) % 4;
    above = m_disp >> (4 * slot);
    lzb   = m_lz && (slot > 0) && (above == 16'd0);
    chk("select", 16'(select), 16'(slot));
    chk("digit", 16'(digit), above & 16'hf);
    chk("blank", 16'(blank), 16'((cnt < G) || lzb));
    chk("frame_tick", 16'(frame_tick),
        16'((cnt == TD - 1) && (slot == 3)));
    chk("upd_ready", 16'(u_if.upd_ready), 16'(!m_pv));
  endtask

  task automatic step(input bit v, input logic [15:0] val, input bit lz);
    int cnt;
    int slot;
    check_now();
    u_if.upd_valid = v;
    {u_if.thousand, u_if.hunnid, u_if.ten, u_if.one} = val;
    lz_en = lz;
    cnt  = k % TD;
    slot = (k / TD) % 4;
    if (cnt == TD - 1 && slot == 3 && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end else if (v && !m_pv) begin
      m_pend = val;
      m_pv   = 1'b1;
    end
    if (cnt == 0)
      m_lz = lz;
    k++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, rval(), lz_g);
  endtask

  task automatic idle_to(input int phase);
    int guard = 0;
    while ((k % (4 * TD)) != phase && guard < 64) begin
      step(1'b0, rval(), lz_g);
      guard++;
    end
  endtask

  task automatic offer(input logic [15:0] val);
    step(1'b1, val, lz_g);
    idle(2 * 4 * TD);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    u_if.upd_valid = 1'($urandom);
    {u_if.thousand, u_if.hunnid, u_if.ten, u_if.one} = rval();
    repeat (3) begin
      @(negedge clk);
      chk("rst_select", 16'(select), 16'd0);
      chk("rst_digit", 16'(digit), 16'd0);
      chk("rst_blank", 16'(blank), 16'd1);
      chk("rst_frame_tick", 16'(frame_tick), 16'd0);
      chk("rst_upd_ready", 16'(u_if.upd_ready), 16'd1);
    end
    reset  = 1'b0;
    k      = 0;
    m_disp = 16'd0;
    m_pend = 16'd0;
    m_pv   = 1'b0;
    m_lz   = 1'b0;
  endtask

  initial begin
    u_if.upd_valid = 1'b0;
    {u_if.thousand, u_if.hunnid, u_if.ten, u_if.one} = 16'd0;
    lz_g = 1'b0;
    do_reset();

    idle(80);

    idle_to(TD + 3);
    offer(16'h1234);

    lz_g = 1'b1;
    offer(16'h0007);
    offer(16'h0000);
    offer(16'h1005);
    offer(16'h0030);

    lz_g = 1'b0;
    step(1'b1, 16'h0042, lz_g);
    repeat (80) step(1'b1, 16'h0099, lz_g);
    idle(40);

    step(1'b1, 16'h0007, lz_g);
    idle(70);
    for (int i = 0; i < 96; i++) begin
      if ((k % TD) == 4)
        lz_g = !lz_g;
      step(1'b0, rval(), lz_g);
    end

    idle_to(TD + 2);
    step(1'b1, 16'h0508, lz_g);
    idle_to(2 * TD + 3);
    do_reset();
    idle(80);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0)
        lz_g = !lz_g;
      step($urandom_range(0, 3) == 0, rval(), lz_g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
